// File: rtl/pipe_stage_buf_pkg.sv
// Shared defaults and state encoding for the fetch/decode pipeline stage buffer.
package pipe_stage_buf_pkg;

    localparam int unsigned INST_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 32;

    // addi x0,x0,0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage : pipe_stage_buf_pkg

// File: rtl/pipe_stage_buf_pipe_entry.sv
// One storage slot: valid bit plus payload, loaded only on demand.
module pipe_entry #(
    parameter int unsigned W       = 64,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Clear beats load; payload only changes on a real load to avoid toggling.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else begin
            if (clr_i) begin
                valid_q <= 1'b0;
            end else if (ld_i) begin
                valid_q <= 1'b1;
                data_q  <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : pipe_entry

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with registered ready, 2-entry skid buffer and flush.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned        INST_W   = INST_W_DEF,
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter logic [INST_W-1:0]  NOP_VAL  = INST_W'(INST_NOP),
    parameter logic [ADDR_W-1:0]  ADDR_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o
);

    localparam int unsigned PAY_W = INST_W + ADDR_W;
    localparam logic [PAY_W-1:0] PAY_RST = {NOP_VAL, ADDR_RST};

    logic             ready_q;
    logic             ready_d;
    logic             main_v;
    logic             skid_v;
    logic [PAY_W-1:0] main_data;
    logic [PAY_W-1:0] skid_data;
    logic [PAY_W-1:0] main_in;
    logic             main_ld;
    logic             main_clr;
    logic             main_sel_skid;
    logic             skid_ld;
    logic             skid_clr;
    logic             accept;
    logic             drain;
    state_e           state_q;
    state_e           state_d;

    assign accept = valid_i & ready_q;
    assign drain  = main_v & ready_i;

    // Occupancy is held in the entry valid bits; skid-without-main decodes as EMPTY.
    always_comb begin
        state_q = ST_EMPTY;
        if (main_v) begin
            state_q = skid_v ? ST_TWO : ST_ONE;
        end
    end

    // Next-state and entry control.
    always_comb begin
        state_d       = state_q;
        main_ld       = 1'b0;
        main_clr      = 1'b0;
        main_sel_skid = 1'b0;
        skid_ld       = 1'b0;
        skid_clr      = 1'b0;
        if (flush_i) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_ld = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        skid_ld = 1'b1;
                        state_d = ST_TWO;
                    end else if (drain) begin
                        main_clr = 1'b1;
                        state_d  = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        main_ld       = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clr      = 1'b1;
                        state_d       = ST_ONE;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                    state_d  = ST_EMPTY;
                end
            endcase
        end
    end

    assign ready_d = (state_d != ST_TWO);

    // Registered ready: high whenever the skid slot will be free next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign main_in = main_sel_skid ? skid_data : {inst_i, inst_addr_i};

    pipe_entry #(
        .W       (PAY_W),
        .RST_VAL (PAY_RST)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (main_clr),
        .ld_i    (main_ld),
        .data_i  (main_in),
        .valid_o (main_v),
        .data_o  (main_data)
    );

    pipe_entry #(
        .W       (PAY_W),
        .RST_VAL (PAY_RST)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (skid_clr),
        .ld_i    (skid_ld),
        .data_i  ({inst_i, inst_addr_i}),
        .valid_o (skid_v),
        .data_o  (skid_data)
    );

    assign ready_o     = ready_q;
    assign valid_o     = main_v;
    assign inst_o      = main_v ? main_data[PAY_W-1 -: INST_W] : NOP_VAL;
    assign inst_addr_o = main_v ? main_data[ADDR_W-1:0]        : ADDR_RST;

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf against a queue-based FIFO model.
module tb_pipe_stage_buf;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } pl_t;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    int checks = 0;
    int errors = 0;

    pl_t  q[$];
    logic ready_m = 1'b1;

    pipe_stage_buf dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, advance the FIFO model at the edge, then compare outputs.
    task automatic step(input logic r, input logic f, input logic v, input logic rdy,
                        input logic [31:0] inst, input logic [31:0] addr);
        logic acc;
        logic drn;
        pl_t  p;
        rst         = r;
        flush_i     = f;
        valid_i     = v;
        ready_i     = rdy;
        inst_i      = inst;
        inst_addr_i = addr;
        @(posedge clk);
        if (r || f) begin
            q.delete();
        end else begin
            acc = v && ready_m;
            drn = (q.size() != 0) && rdy;
            if (drn) void'(q.pop_front());
            if (acc) begin
                p.inst = inst;
                p.addr = addr;
                q.push_back(p);
            end
        end
        ready_m = (q.size() < 2);
        @(negedge clk);
        chk("valid_o", 64'(valid_o), 64'(q.size() != 0));
        chk("ready_o", 64'(ready_o), 64'(ready_m));
        chk("inst_o", 64'(inst_o), 64'((q.size() != 0) ? q[0].inst : NOP));
        chk("inst_addr_o", 64'(inst_addr_o), 64'((q.size() != 0) ? q[0].addr : 32'h0));
        chk("skid_without_main", 64'(dut.u_skid.valid_o & ~dut.u_main.valid_o), 64'(0));
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        inst_i = '0; inst_addr_i = '0;
        @(negedge clk);

        // Reset held two cycles with a live payload on the input.
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 1, 0, 32'hDEADBEEF, 32'h100);
            chk("rst_valid", 64'(valid_o), 64'(0));
            chk("rst_inst", 64'(inst_o), 64'(NOP));
            chk("rst_ready", 64'(ready_o), 64'(1));
        end

        // Streaming with ready_i high: one-cycle latency, ready never drops.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 32'hA000_0000 + 32'(i), 32'(4 * i));
            chk("stream_addr", 64'(inst_addr_o), 64'(4 * i));
            chk("stream_ready", 64'(ready_o), 64'(1));
        end
        step(0, 0, 0, 1, 0, 0);
        chk("stream_done", 64'(valid_o), 64'(0));

        // Backpressure: A then B fill the buffer, C is ignored.
        step(0, 0, 1, 0, 32'h1111_1111, 32'h10);
        step(0, 0, 1, 0, 32'h2222_2222, 32'h14);
        chk("bp_ready_low", 64'(ready_o), 64'(0));
        step(0, 0, 1, 0, 32'h3333_3333, 32'h18);
        chk("bp_hold_a", 64'(inst_addr_o), 64'h10);
        step(0, 0, 0, 1, 0, 0);
        chk("bp_b_next", 64'(inst_addr_o), 64'h14);
        chk("bp_ready_back", 64'(ready_o), 64'(1));
        step(0, 0, 0, 1, 0, 0);
        chk("bp_empty", 64'(valid_o), 64'(0));

        // Flush while holding A,B, with D offered in the same cycle.
        step(0, 0, 1, 0, 32'h1111_1111, 32'h10);
        step(0, 0, 1, 0, 32'h2222_2222, 32'h14);
        step(0, 1, 1, 0, 32'h4444_4444, 32'h40);
        chk("flush_valid", 64'(valid_o), 64'(0));
        chk("flush_inst", 64'(inst_o), 64'(NOP));
        chk("flush_ready", 64'(ready_o), 64'(1));
        step(0, 0, 0, 1, 0, 0);
        chk("flush_no_residue", 64'(valid_o), 64'(0));

        // Reset pulse while in ONE, then a fresh payload E.
        step(0, 0, 1, 0, 32'h5555_5555, 32'h50);
        step(1, 0, 0, 0, 0, 0);
        chk("midrst_valid", 64'(valid_o), 64'(0));
        chk("midrst_addr", 64'(inst_addr_o), 64'(0));
        step(0, 0, 1, 0, 32'hEEEE_EEEE, 32'h80);
        chk("midrst_e_addr", 64'(inst_addr_o), 64'h80);
        chk("midrst_e_inst", 64'(inst_o), 64'hEEEE_EEEE);

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                 $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_stage_buf
